serial_ripple_adder: RTL and testbench
======================================

# serial_ripple_adder

Parametrised, multi-cycle segmented ripple-carry adder for the low-power floating-point adder datapath. It computes `a + b + cin` over `WIDTH` bits, one `SEG`-bit ripple slice per clock, and carries the inter-segment carry in a register. This trades latency for a short critical path and low switching activity in the mantissa add stage. Operands enter and the result leaves through valid/ready handshakes.

## Interface
- `WIDTH`, 24: operand and sum width. Must be a multiple of `SEG`.
- `SEG`, 4: bits added per cycle. 1 ≤ `SEG` ≤ `WIDTH`.
- `NSEG`: derived constant, equal to `WIDTH/SEG`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B.
- `cin` in 1: carry-in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `sum` out `WIDTH`: registered sum.
- `cout` out 1: registered carry-out.
- `busy` out 1: state is not IDLE.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a`/`b` into operand registers, set carry register ← `cin`, `idx` ← 0, clear the `sum` register to 0, go to RUN.
- RUN, each cycle:
  - Compute `{c, s}` = `a[idx*SEG +: SEG]` + `b[idx*SEG +: SEG]` + carry.
  - Write `s` into `sum[idx*SEG +: SEG]` only; other segments are not clocked.
  - carry ← `c`; `idx` ← `idx`+1.
  - When `idx`==`NSEG`-1: `cout` ← `c`, go to DONE.
- DONE:
  - `out_valid`=1.
  - `sum` and `cout` are held stable until `out_ready`.
  - On `out_valid && out_ready`: go to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` is ignored there, and operands are not sampled.
- `out_ready` is ignored outside DONE.
- `sum` contents are meaningful only while `out_valid`=1.
- Arithmetic is unsigned modulo 2^`WIDTH`; the bit-`WIDTH` overflow appears only on `cout`.
- Operand registers load only on accept, for power.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, carry=0, `idx`=0.
- Reset mid-operation: asynchronous return to IDLE with the values above. The in-flight operation is discarded and no `out_valid` pulse is produced.

## Timing
- Accept edge E0 → `out_valid` high after edge E`NSEG`. Latency is `NSEG` cycles; `SEG`=`WIDTH` gives 1 cycle.
- With `out_ready` held high: IDLE is re-entered at E`NSEG`+1 and the next accept is at E`NSEG`+2. Minimum initiation interval is `NSEG`+2 cycles.
- `in_ready`, `out_valid` and `busy` are pure decodes of the registered state. There are no combinational input-to-output paths.
- The critical path is a single `SEG`-bit ripple plus the segment mux.

## Configuration
- `SERIAL_ADD_EARLY_EXIT_EN` defined:
  - In RUN, when `idx` < `NSEG`-1, `c`==0, and all bits of both operand registers above segment `idx` are zero: `cout` ← 0 and go straight to DONE.
  - The upper `sum` segments keep their cleared value of 0.
  - Latency becomes data-dependent, from 1 to `NSEG` cycles.
- `SERIAL_ADD_EARLY_EXIT_EN` undefined:
  - Latency is always exactly `NSEG`.
  - The zero-detect logic is absent.

## Structure
- Package `serial_add_pkg` holds:
  - state enum `serial_add_state_t` (IDLE, RUN, DONE);
  - helper function computing the `idx` width, clog2 of `NSEG` with minimum 1.
- Sub-module `seg_ripple_cell`:
  - purely combinational, parametrised by `SEG`;
  - bitwise full-adder chain, inputs `a_seg`, `b_seg`, `ci`, outputs `s_seg`, `co`;
  - instantiated once and fed by the segment mux.

## Test plan
All scenarios use `WIDTH`=16, `SEG`=4, so `NSEG`=4.
- **Basic add:** `a`=0x1234, `b`=0x0FFF, `cin`=0 → `sum`=0x2233, `cout`=0, `out_valid` 4 cycles after accept.
- **Full carry chain:** `a`=0xFFFF, `b`=0x0000, `cin`=1 → `sum`=0x0000, `cout`=1. Latency is 4 cycles in both configurations.
- **Backpressure:** `out_ready` held low for 5 cycles in DONE → `sum`, `cout`, `out_valid` stable and `in_ready`=0. A new `in_valid` with 0xAAAA/0x5555 is ignored. After `out_ready`, IDLE, then the next operation completes correctly.
- **Reset mid-RUN:** drop `rst_n` 2 cycles after accepting 0x8000+0x8000 → immediately `out_valid`=0, `sum`=0, `cout`=0, `busy`=0. After release, `in_ready`=1 and the next op, 0x0001+0x0001, gives 0x0002.
- **Early exit:** `a`=0x0003, `b`=0x0004, `cin`=0 → `sum`=0x0007, `cout`=0. `out_valid` after 1 cycle with `SERIAL_ADD_EARLY_EXIT_EN`, after 4 cycles without.
- **Streaming:** `out_ready` tied high, 1000 random operand/cin triples → every result matches `a+b+cin` at 17 bits. Accept spacing is exactly 6 cycles without early exit.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the segmented serial ripple adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_add_state_t;

    // Segment index width: clog2 of the segment count, never narrower than one bit.
    function automatic int idx_width(input int nseg);
        int w;
        w = $clog2(nseg);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg_ripple_cell.sv
// One SEG-bit slice of the adder: a plain bitwise full-adder chain, no state.
module seg_ripple_cell #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           ci,
    output logic [SEG-1:0] s_seg,
    output logic           co
);

    logic [SEG:0] carry_s;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        carry_s    = '0;
        s_seg      = '0;
        carry_s[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s_seg[i]     = a_seg[i] ^ b_seg[i] ^ carry_s[i];
            carry_s[i+1] = (a_seg[i] & b_seg[i]) | (carry_s[i] & (a_seg[i] ^ b_seg[i]));
        end
        co = carry_s[SEG];
    end

endmodule

// File: rtl/serial_ripple_adder.sv
// Multi-cycle segmented ripple adder: one SEG-bit slice per clock, carry held in a flop.
// Optional build macro SERIAL_ADD_EARLY_EXIT_EN enables the zero-operand early exit.
module serial_ripple_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSEG = WIDTH / SEG;
    localparam int IDXW = idx_width(NSEG);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

    serial_add_state_t state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic [SEG-1:0]    a_seg_s;
    logic [SEG-1:0]    b_seg_s;
    logic [SEG-1:0]    s_seg_s;
    logic              co_s;
    logic              early_exit_s;

    assign a_seg_s = a_q[int'(idx_q)*SEG +: SEG];
    assign b_seg_s = b_q[int'(idx_q)*SEG +: SEG];

    seg_ripple_cell #(
        .SEG (SEG)
    ) u_cell (
        .a_seg (a_seg_s),
        .b_seg (b_seg_s),
        .ci    (carry_q),
        .s_seg (s_seg_s),
        .co    (co_s)
    );

`ifdef SERIAL_ADD_EARLY_EXIT_EN
    logic [WIDTH-1:0] upper_s;

    // Nothing left to add once the carry dies and every higher operand bit is zero.
    always_comb begin
        upper_s      = (a_q | b_q) >> ((int'(idx_q) + 1) * SEG);
        early_exit_s = (idx_q < LAST_IDX) && !co_s && (upper_s == '0);
    end
`else
    assign early_exit_s = 1'b0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*SEG +: SEG] = s_seg_s;
                carry_d = co_s;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = co_s;
                    state_d = DONE;
                end else if (early_exit_s) begin
                    cout_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Directed self-checking bench for serial_ripple_adder at WIDTH=16, SEG=4.
module tb_serial_ripple_adder;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
`ifdef SERIAL_ADD_EARLY_EXIT_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    serial_ripple_adder #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Waits for in_ready, issues one operation and returns at the first negedge with out_valid.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_cin,
                          output logic [16:0] res, output int lat, output int acc_cyc);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("out_valid_seen", 32'(out_valid), 32'd1);
        res = {cout, sum};
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic [16:0] vexp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [16:0] res;
        logic [16:0] exp_res;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [15:0] held_sum;
        logic        held_cout;
        int          lat;
        int          acc;
        int          prev_acc;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
        vecs[1] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
        vecs[2] = '{16'h00FF, 16'hFF01, 1'b0, 17'h10000};
        vecs[3] = '{16'hABCD, 16'h1234, 1'b1, 17'h0BE02};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        run_op(16'h1234, 16'h0FFF, 1'b0, res, lat, acc);
        check_eq("basic_sum", 32'(res), 32'h02233);
        check_eq("basic_lat", 32'(lat), 32'd4);

        run_op(16'hFFFF, 16'h0000, 1'b1, res, lat, acc);
        check_eq("carry_chain_sum", 32'(res), 32'h10000);
        check_eq("carry_chain_lat", 32'(lat), 32'd4);

        run_op(16'h0003, 16'h0004, 1'b0, res, lat, acc);
        check_eq("early_exit_sum", 32'(res), 32'h00007);
        check_eq("early_exit_lat", 32'(lat), 32'(SMALL_LAT));

        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, res, lat, acc);
            check_eq($sformatf("vec%0d_sum", i), 32'(res), 32'(vecs[i].vexp));
        end

        // Backpressure: let the last result drain, then stall the next one in DONE.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b1, res, lat, acc);
        check_eq("bp_sum", 32'(res), 32'h03334);
        held_sum  = sum;
        held_cout = cout;
        a         = 16'hAAAA;
        b         = 16'h5555;
        cin       = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_sum_stable", 32'(sum), 32'(held_sum));
            check_eq("bp_cout_stable", 32'(cout), 32'(held_cout));
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_idle_busy", 32'(busy), 32'd0);
        check_eq("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("bp_idle_out_valid", 32'(out_valid), 32'd0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, res, lat, acc);
        check_eq("bp_next_sum", 32'(res), 32'h01000);
        check_eq("bp_next_lat", 32'(lat), 32'd4);

        // Reset two cycles into an operation.
        @(negedge clk);
        a        = 16'h8000;
        b        = 16'h8000;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_sum", 32'(sum), 32'd0);
        check_eq("midrst_cout", 32'(cout), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("postrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("postrst_out_valid", 32'(out_valid), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, res, lat, acc);
        check_eq("postrst_sum", 32'(res), 32'h00002);

        // Streaming with out_ready held high.
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            exp_res = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            run_op(ra, rb, rc, res, lat, acc);
            check_eq($sformatf("stream%0d_sum", i), 32'(res), 32'(exp_res));
`ifndef SERIAL_ADD_EARLY_EXIT_EN
            if (i > 0) check_eq($sformatf("stream%0d_spacing", i), 32'(acc - prev_acc), 32'd6);
`endif
            prev_acc = acc;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
